game_turn_controller: RTL and testbench

// - Sequences play on the shared position-decoder / position-register datapath.
// - Alternates player and computer turns, edge-detects the move buttons and rejects illegal moves.
// - Tracks board occupancy and the move count; issues one-cycle write-enable and position-code strobes.
// - Stops play on a win or a full board.

---
 rtl/game_turn_controller.sv | 135 +++++++++++++
 tb/tb_game_turn_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_controller.sv
// Turn sequencer for the shared position-decoder / position-register datapath:
// alternates player/computer moves, rejects illegal moves, stops on win or full board.
module game_turn_controller #(
  parameter int unsigned NUM_POS = 9,
  parameter int unsigned POS_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_game,
  input  logic             play,
  input  logic             pc,
  input  logic [POS_W-1:0] player_pos,
  input  logic [POS_W-1:0] computer_pos,
  input  logic             win_detect,
  output logic             dec_en,
  output logic [POS_W-1:0] dec_pos,
  output logic             dec_player,
  output logic             illegal_move,
  output logic             turn,
  output logic [3:0]       move_count,
  output logic             game_over,
  output logic             board_full
);

  localparam logic [POS_W:0] NPOS = (POS_W+1)'(NUM_POS);
  localparam logic [4:0]     FULL = 5'(NUM_POS);

  typedef enum logic [2:0] {
    P_WAIT, P_WRITE, C_WAIT, C_WRITE, CHECK, DONE
  } state_t;

  state_t                  state, state_n;
  logic [POS_W-1:0]        pos_q, pos_n;
  logic [(2**POS_W)-1:0]   occ, occ_n;
  logic [4:0]              cnt, cnt_n;
  logic                    turn_q, turn_n;
  logic                    ill_q, ill_n;
  logic                    play_q, pc_q;
  logic                    play_rise, pc_rise;
  logic                    p_legal, c_legal;

  assign play_rise = play & ~play_q;
  assign pc_rise   = pc & ~pc_q;

  // Range check first: occupancy is sized to the full code space, so indexing is always safe.
  assign p_legal = ({1'b0, player_pos} < NPOS) && !occ[player_pos];
  assign c_legal = ({1'b0, computer_pos} < NPOS) && !occ[computer_pos];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= P_WAIT;
      pos_q  <= '0;
      occ    <= '0;
      cnt    <= '0;
      turn_q <= 1'b0;
      ill_q  <= 1'b0;
      play_q <= 1'b0;
      pc_q   <= 1'b0;
    end else if (new_game) begin
      state  <= P_WAIT;
      pos_q  <= '0;
      occ    <= '0;
      cnt    <= '0;
      turn_q <= 1'b0;
      ill_q  <= 1'b0;
      play_q <= 1'b0;
      pc_q   <= 1'b0;
    end else begin
      state  <= state_n;
      pos_q  <= pos_n;
      occ    <= occ_n;
      cnt    <= cnt_n;
      turn_q <= turn_n;
      ill_q  <= ill_n;
      play_q <= play;
      pc_q   <= pc;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    occ_n   = occ;
    cnt_n   = cnt;
    turn_n  = turn_q;
    ill_n   = 1'b0;
    case (state)
      P_WAIT: begin
        if (play_rise) begin
          if (p_legal) begin
            pos_n   = player_pos;
            state_n = P_WRITE;
          end else begin
            ill_n = 1'b1;
          end
        end
      end
      C_WAIT: begin
        if (pc_rise) begin
          if (c_legal) begin
            pos_n   = computer_pos;
            state_n = C_WRITE;
          end else begin
            ill_n = 1'b1;
          end
        end
      end
      P_WRITE, C_WRITE: begin
        occ_n[pos_q] = 1'b1;
        if (cnt != FULL) cnt_n = cnt + 5'd1;
        state_n = CHECK;
      end
      CHECK: begin
        if (win_detect || (cnt == FULL)) begin
          state_n = DONE;
        end else begin
          state_n = turn_q ? P_WAIT : C_WAIT;
          turn_n  = ~turn_q;
        end
      end
      DONE: state_n = DONE;
      default: state_n = P_WAIT;
    endcase
  end

  assign dec_en       = (state == P_WRITE) || (state == C_WRITE);
  assign dec_pos      = dec_en ? pos_q : '0;
  assign dec_player   = (state == P_WRITE);
  assign illegal_move = ill_q;
  assign turn         = turn_q;
  assign move_count   = cnt[3:0];
  assign game_over    = (state == DONE);
  assign board_full   = (cnt == FULL);

endmodule

// File: tb/tb_game_turn_controller.sv
// Self-checking bench: directed literal scenarios plus random play against a behavioural game model.
module tb_game_turn_controller;
  localparam int NP = 9;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       play = 1'b0;
  logic       pc = 1'b0;
  logic [3:0] player_pos = '0;
  logic [3:0] computer_pos = '0;
  logic       win_detect = 1'b0;
  logic       dec_en;
  logic [3:0] dec_pos;
  logic       dec_player;
  logic       illegal_move;
  logic       turn;
  logic [3:0] move_count;
  logic       game_over;
  logic       board_full;

  game_turn_controller #(.NUM_POS(NP), .POS_W(4)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .play(play), .pc(pc),
    .player_pos(player_pos), .computer_pos(computer_pos), .win_detect(win_detect),
    .dec_en(dec_en), .dec_pos(dec_pos), .dec_player(dec_player),
    .illegal_move(illegal_move), .turn(turn), .move_count(move_count),
    .game_over(game_over), .board_full(board_full)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase counts cycles since a move was accepted (0 = waiting for a move).
  bit m_occ[16];
  int m_count, m_phase, m_pos;
  bit m_cturn, m_over, m_ill, m_play_q, m_pc_q;

  task automatic model_clear();
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    m_count = 0; m_phase = 0; m_pos = 0;
    m_cturn = 0; m_over = 0; m_ill = 0; m_play_q = 0; m_pc_q = 0;
  endtask

  task automatic model_step();
    bit prise, crise, rise;
    int p;
    prise = play && !m_play_q;
    crise = pc && !m_pc_q;
    m_ill = 0;
    if (!m_over) begin
      if (m_phase == 0) begin
        rise = m_cturn ? crise : prise;
        p = m_cturn ? int'(computer_pos) : int'(player_pos);
        if (rise) begin
          if (p < NP && !m_occ[p]) begin
            m_pos = p;
            m_phase = 1;
          end else begin
            m_ill = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_occ[m_pos] = 1;
        if (m_count < NP) m_count++;
        m_phase = 2;
      end else begin
        if (win_detect || m_count == NP) m_over = 1;
        else m_cturn = !m_cturn;
        m_phase = 0;
      end
    end
    m_play_q = play;
    m_pc_q = pc;
  endtask

  initial model_clear();

  always @(posedge clock or posedge reset) begin
    if (reset || new_game) model_clear();
    else model_step();
  end

  bit check_en = 0;
  always @(negedge clock) begin
    if (check_en && !reset) begin
      chk("m_dec_en", int'(dec_en), int'(m_phase == 1));
      chk("m_dec_pos", int'(dec_pos), (m_phase == 1) ? m_pos : 0);
      chk("m_dec_player", int'(dec_player), int'(m_phase == 1 && !m_cturn));
      chk("m_illegal", int'(illegal_move), int'(m_ill));
      chk("m_turn", int'(turn), int'(m_cturn));
      chk("m_count", int'(move_count), m_count);
      chk("m_game_over", int'(game_over), int'(m_over));
      chk("m_board_full", int'(board_full), int'(m_count == NP));
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, int'(dec_en), 0);
    chk({tag, "_pos"}, int'(dec_pos), 0);
    chk({tag, "_ill"}, int'(illegal_move), 0);
    chk({tag, "_turn"}, int'(turn), 0);
    chk({tag, "_cnt"}, int'(move_count), 0);
    chk({tag, "_over"}, int'(game_over), 0);
    chk({tag, "_full"}, int'(board_full), 0);
  endtask

  task automatic do_move(input bit side, input logic [3:0] p);
    if (side) begin computer_pos = p; pc = 1; end
    else begin player_pos = p; play = 1; end
    step();
    chk("mv_en", int'(dec_en), 1);
    chk("mv_pos", int'(dec_pos), int'(p));
    chk("mv_player", int'(dec_player), int'(!side));
    play = 0; pc = 0;
    step();
    step();
  endtask

  initial begin
    int strobes;
    repeat (2) step();
    reset = 0;
    check_en = 1;
    step();
    chk_idle("rst");

    player_pos = 4'd4; play = 1;
    step();
    chk("p4_en", int'(dec_en), 1);
    chk("p4_pos", int'(dec_pos), 4);
    chk("p4_player", int'(dec_player), 1);
    play = 0;
    step();
    chk("p4_check_en", int'(dec_en), 0);
    chk("p4_check_turn", int'(turn), 0);
    step();
    chk("p4_turn", int'(turn), 1);
    chk("p4_cnt", int'(move_count), 1);

    computer_pos = 4'd4; pc = 1;
    step();
    chk("c4_ill", int'(illegal_move), 1);
    chk("c4_en", int'(dec_en), 0);
    pc = 0;
    step();
    chk("c4_ill_clr", int'(illegal_move), 0);
    chk("c4_turn", int'(turn), 1);
    computer_pos = 4'd0; pc = 1;
    step();
    chk("c0_en", int'(dec_en), 1);
    chk("c0_pos", int'(dec_pos), 0);
    chk("c0_player", int'(dec_player), 0);
    pc = 0;
    step(); step();
    chk("c0_turn", int'(turn), 0);
    chk("c0_cnt", int'(move_count), 2);

    player_pos = 4'd12; play = 1;
    step();
    chk("p12_ill", int'(illegal_move), 1);
    chk("p12_en", int'(dec_en), 0);
    play = 0;
    step();
    chk("p12_turn", int'(turn), 0);
    pc = 1;
    step();
    chk("pc_in_pwait_en", int'(dec_en), 0);
    pc = 0;
    step();
    chk("pc_in_pwait_turn", int'(turn), 0);

    player_pos = 4'd1; play = 1;
    strobes = 0;
    repeat (20) begin
      step();
      if (dec_en) strobes++;
    end
    chk("hold_strobes", strobes, 1);
    play = 0;

    new_game = 1;
    step();
    new_game = 0;
    chk_idle("ng1");

    for (int i = 0; i < 9; i++) do_move(i[0], 4'(i));
    chk("full_bf", int'(board_full), 1);
    chk("full_go", int'(game_over), 1);
    chk("full_cnt", int'(move_count), 9);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      play = ~play; pc = ~pc; player_pos = 4'(i); computer_pos = 4'(i);
      step();
      if (dec_en) strobes++;
    end
    chk("done_strobes", strobes, 0);
    play = 0; pc = 0;

    new_game = 1;
    step();
    new_game = 0;
    chk_idle("ng2");
    for (int i = 0; i < 5; i++) begin
      win_detect = (i == 4);
      do_move(i[0], 4'(i + 2));
    end
    win_detect = 0;
    chk("win_go", int'(game_over), 1);
    chk("win_cnt", int'(move_count), 5);
    chk("win_bf", int'(board_full), 0);
    new_game = 1;
    step();
    new_game = 0;
    chk_idle("ng3");

    player_pos = 4'd3; play = 1;
    @(posedge clock);
    #1;
    chk("ar_en_before", int'(dec_en), 1);
    reset = 1;
    #1;
    chk("ar_en_after", int'(dec_en), 0);
    chk("ar_cnt", int'(move_count), 0);
    play = 0;
    @(negedge clock);
    #2 reset = 0;
    step();
    chk_idle("ar");

    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) play = ~play;
      if ($urandom_range(0, 3) == 0) pc = ~pc;
      player_pos = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      computer_pos = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      win_detect = ($urandom_range(0, 9) == 0);
      new_game = ($urandom_range(0, 149) == 0);
      step();
    end
    new_game = 0;
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
